// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the XOR-cipher configuration receiver.
//  - cfg_width(m): frame width for an m-bit LFSR pair (4*m+2).
//  - Field offsets within the frame word for the default M=32 build.
//  - FSM state encoding.
package xor_cipher_pkg;

    localparam int unsigned CFG_M = 32;

    function automatic int unsigned cfg_width(input int unsigned m);
        return 4 * m + 2;
    endfunction

    localparam int unsigned MUX_EXT_A_BIT = 4 * CFG_M + 1;
    localparam int unsigned MUX_EN_D_BIT  = 4 * CFG_M;
    localparam int unsigned TX_TAPS_LSB   = 3 * CFG_M;
    localparam int unsigned TX_STATE_LSB  = 2 * CFG_M;
    localparam int unsigned RX_TAPS_LSB   = CFG_M;
    localparam int unsigned RX_STATE_LSB  = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } cfg_state_e;

endpackage

// File: rtl/xor_cfg_shift_reg.sv
// W-bit right-shift register: serial data enters at the MSB, the LSB is exposed
// as a tap for daisy-chaining.
//  clk, rst : clock, synchronous active-high reset
//  en       : shift enable
//  din      : serial input
//  q        : parallel contents
//  tap      : q[0]
module xor_cfg_shift_reg #(
    parameter int unsigned W = 130
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] q,
    output logic         tap
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= {din, q[W-1:1]};
        end
    end

    assign tap = q[0];

endmodule

// File: rtl/xor_cipher_cfg_rx.sv
// Serial configuration receiver for the dual-XOR LFSR cipher.
// Deserialises a 4*M+2-bit frame (LSB first) into a shadow register and commits
// it to the active register only when exactly W bits were received.
//  clk, rst       : clock, synchronous active-high reset
//  cfg_en, cfg_i  : frame strobe and serial data
//  cfg_o          : shadow[0], for chaining another receiver
//  ld             : one-cycle pulse on commit
//  cfg_valid      : a frame has committed since reset
//  cfg_err        : sticky, last frame had the wrong length
//  busy           : receiving a frame
//  mux_ext_a .. rx_lfsr_state : fields of the active configuration
module xor_cipher_cfg_rx
    import xor_cipher_pkg::*;
#(
    parameter int unsigned         M           = 32,
    parameter int unsigned         CNT_W       = 11,
    parameter logic [4*M+1:0]      DEFAULT_CFG = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_en,
    input  logic         cfg_i,
    output logic         cfg_o,
    output logic         ld,
    output logic         cfg_valid,
    output logic         cfg_err,
    output logic         busy,
    output logic         mux_ext_a,
    output logic         mux_en_d,
    output logic [M-1:0] tx_lfsr_taps,
    output logic [M-1:0] tx_lfsr_state,
    output logic [M-1:0] rx_lfsr_taps,
    output logic [M-1:0] rx_lfsr_state
);

    localparam int unsigned W = cfg_width(M);
    // Counter stops one past W so an overrun can never alias to a valid length.
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(W + 1);

    cfg_state_e       state, state_d;
    logic [CNT_W-1:0] count, count_d;
    logic [W-1:0]     active, active_d;
    logic [W-1:0]     shadow;
    logic             ld_d, cfg_valid_d, cfg_err_d;

    // Shadow shifts on every enabled cycle regardless of FSM state.
    xor_cfg_shift_reg #(
        .W (W)
    ) u_shift (
        .clk (clk),
        .rst (rst),
        .en  (cfg_en),
        .din (cfg_i),
        .q   (shadow),
        .tap (cfg_o)
    );

    // State, counter and commit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            active    <= DEFAULT_CFG;
            ld        <= 1'b0;
            cfg_valid <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_d;
            count     <= count_d;
            active    <= active_d;
            ld        <= ld_d;
            cfg_valid <= cfg_valid_d;
            cfg_err   <= cfg_err_d;
        end
    end

    // Next-state, bit counting and end-of-frame commit decision.
    always_comb begin
        state_d     = state;
        count_d     = count;
        active_d    = active;
        ld_d        = 1'b0;
        cfg_valid_d = cfg_valid;
        cfg_err_d   = cfg_err;
        case (state)
            ST_IDLE: begin
                if (cfg_en) begin
                    state_d = ST_SHIFT;
                    count_d = CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (cfg_en) begin
                    if (count != CNT_SAT) begin
                        count_d = count + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    if (count == CNT_FULL) begin
                        active_d    = shadow;
                        ld_d        = 1'b1;
                        cfg_valid_d = 1'b1;
                        cfg_err_d   = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_SHIFT);

    // Fields come only from the committed word, so they hold steady mid-frame.
    assign mux_ext_a     = active[4*M+1];
    assign mux_en_d      = active[4*M];
    assign tx_lfsr_taps  = active[4*M-1:3*M];
    assign tx_lfsr_state = active[3*M-1:2*M];
    assign rx_lfsr_taps  = active[2*M-1:M];
    assign rx_lfsr_state = active[M-1:0];

endmodule

// File: tb/tb_xor_cipher_cfg_rx.sv
module tb_xor_cipher_cfg_rx;

    localparam int unsigned M = 32;
    localparam int unsigned W = 4 * M + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_en = 1'b0;
    logic cfg_i = 1'b0;

    logic         cfg_o, ld, cfg_valid, cfg_err, busy, mux_ext_a, mux_en_d;
    logic [M-1:0] tx_lfsr_taps, tx_lfsr_state, rx_lfsr_taps, rx_lfsr_state;

    logic         c_cfg_o, c_ld, c_cfg_valid, c_cfg_err, c_busy, c_mux_ext_a, c_mux_en_d;
    logic [M-1:0] c_tx_taps, c_tx_state, c_rx_taps, c_rx_state;

    logic [W-1:0] fields, c_fields;
    assign fields   = {mux_ext_a, mux_en_d, tx_lfsr_taps, tx_lfsr_state, rx_lfsr_taps, rx_lfsr_state};
    assign c_fields = {c_mux_ext_a, c_mux_en_d, c_tx_taps, c_tx_state, c_rx_taps, c_rx_state};

    localparam logic [W-1:0] WORD_A = {1'b1, 1'b0, 32'h80200003, 32'h00000001, 32'h80200003, 32'h00000001};
    localparam logic [W-1:0] WORD_B = {1'b0, 1'b1, 32'h12345678, 32'h9abcdef0, 32'h0f0f0f0f, 32'hdeadbeef};

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    xor_cipher_cfg_rx #(.M(M), .CNT_W(11), .DEFAULT_CFG('0)) u_dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_i(cfg_i), .cfg_o(cfg_o),
        .ld(ld), .cfg_valid(cfg_valid), .cfg_err(cfg_err), .busy(busy),
        .mux_ext_a(mux_ext_a), .mux_en_d(mux_en_d),
        .tx_lfsr_taps(tx_lfsr_taps), .tx_lfsr_state(tx_lfsr_state),
        .rx_lfsr_taps(rx_lfsr_taps), .rx_lfsr_state(rx_lfsr_state)
    );

    // Second receiver fed from the first one's chain output.
    xor_cipher_cfg_rx #(.M(M), .CNT_W(11), .DEFAULT_CFG('0)) u_chain (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_i(cfg_o), .cfg_o(c_cfg_o),
        .ld(c_ld), .cfg_valid(c_cfg_valid), .cfg_err(c_cfg_err), .busy(c_busy),
        .mux_ext_a(c_mux_ext_a), .mux_en_d(c_mux_en_d),
        .tx_lfsr_taps(c_tx_taps), .tx_lfsr_state(c_tx_state),
        .rx_lfsr_taps(c_rx_taps), .rx_lfsr_state(c_rx_state)
    );

    // Drive n bits (LSB first) leaving cfg_en high; bits past W are zero.
    task automatic send_bits(input logic [299:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cfg_en = 1'b1;
            cfg_i  = w[i];
        end
    endtask

    // Drop cfg_en and return just after the edge that sees it low.
    task automatic end_frame();
        @(negedge clk);
        cfg_en = 1'b0;
        cfg_i  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests_run++; if (fields !== '0) begin tests_failed++; $display("FAIL reset_fields got=%h exp=0", fields); end
        tests_run++; if (ld !== 1'b0) begin tests_failed++; $display("FAIL reset_ld got=%b exp=0", ld); end
        tests_run++; if (cfg_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", cfg_valid); end
        tests_run++; if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests_run++; if (cfg_o !== 1'b0) begin tests_failed++; $display("FAIL reset_cfg_o got=%b exp=0", cfg_o); end
    endtask

    task automatic test_full_frame();
        send_bits(300'(WORD_A), W);
        @(negedge clk);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL full_busy got=%b exp=1", busy); end
        tests_run++; if (fields !== '0) begin tests_failed++; $display("FAIL full_fields_stable got=%h exp=0", fields); end
        cfg_en = 1'b0;
        cfg_i  = 1'b0;
        @(negedge clk);
        tests_run++; if (ld !== 1'b1) begin tests_failed++; $display("FAIL full_ld got=%b exp=1", ld); end
        tests_run++; if (fields !== WORD_A) begin tests_failed++; $display("FAIL full_fields got=%h exp=%h", fields, WORD_A); end
        tests_run++; if (tx_lfsr_taps !== 32'h80200003) begin tests_failed++; $display("FAIL full_tx_taps got=%h exp=80200003", tx_lfsr_taps); end
        tests_run++; if (rx_lfsr_state !== 32'h00000001) begin tests_failed++; $display("FAIL full_rx_state got=%h exp=00000001", rx_lfsr_state); end
        tests_run++; if (mux_ext_a !== 1'b1 || mux_en_d !== 1'b0) begin tests_failed++; $display("FAIL full_mux got=%b%b exp=10", mux_ext_a, mux_en_d); end
        tests_run++; if (cfg_valid !== 1'b1) begin tests_failed++; $display("FAIL full_valid got=%b exp=1", cfg_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL full_busy_end got=%b exp=0", busy); end
        @(negedge clk);
        tests_run++; if (ld !== 1'b0) begin tests_failed++; $display("FAIL full_ld_pulse got=%b exp=0", ld); end
    endtask

    task automatic test_short_frame();
        send_bits(300'(WORD_B), W - 1);
        end_frame();
        tests_run++; if (cfg_err !== 1'b1) begin tests_failed++; $display("FAIL short_err got=%b exp=1", cfg_err); end
        tests_run++; if (ld !== 1'b0) begin tests_failed++; $display("FAIL short_ld got=%b exp=0", ld); end
        tests_run++; if (fields !== WORD_A) begin tests_failed++; $display("FAIL short_fields got=%h exp=%h", fields, WORD_A); end
        tests_run++; if (cfg_valid !== 1'b1) begin tests_failed++; $display("FAIL short_valid got=%b exp=1", cfg_valid); end
    endtask

    task automatic test_overrun();
        send_bits(300'(WORD_B), 300);
        @(negedge clk);
        tests_run++; if (u_dut.count !== 11'd131) begin tests_failed++; $display("FAIL overrun_count got=%0d exp=131", u_dut.count); end
        cfg_en = 1'b0;
        cfg_i  = 1'b0;
        @(negedge clk);
        tests_run++; if (cfg_err !== 1'b1) begin tests_failed++; $display("FAIL overrun_err got=%b exp=1", cfg_err); end
        tests_run++; if (ld !== 1'b0) begin tests_failed++; $display("FAIL overrun_ld got=%b exp=0", ld); end
        tests_run++; if (fields !== WORD_A) begin tests_failed++; $display("FAIL overrun_fields got=%h exp=%h", fields, WORD_A); end
        send_bits(300'(WORD_B), W);
        end_frame();
        tests_run++; if (ld !== 1'b1) begin tests_failed++; $display("FAIL overrun_recover_ld got=%b exp=1", ld); end
        tests_run++; if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL overrun_recover_err got=%b exp=0", cfg_err); end
        tests_run++; if (fields !== WORD_B) begin tests_failed++; $display("FAIL overrun_recover_fields got=%h exp=%h", fields, WORD_B); end
    endtask

    task automatic test_reset_mid_frame();
        send_bits(300'(WORD_B), 60);
        @(negedge clk);
        rst    = 1'b1;
        cfg_en = 1'b0;
        cfg_i  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tests_run++; if (fields !== '0) begin tests_failed++; $display("FAIL midrst_fields got=%h exp=0", fields); end
        tests_run++; if (ld !== 1'b0) begin tests_failed++; $display("FAIL midrst_ld got=%b exp=0", ld); end
        tests_run++; if (cfg_valid !== 1'b0 || cfg_err !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_flags got=%b%b%b exp=000", cfg_valid, cfg_err, busy); end
        tests_run++; if (cfg_o !== 1'b0) begin tests_failed++; $display("FAIL midrst_cfg_o got=%b exp=0", cfg_o); end
        @(negedge clk);
        tests_run++; if (ld !== 1'b0) begin tests_failed++; $display("FAIL midrst_ld_after got=%b exp=0", ld); end
        send_bits(300'(WORD_A), W);
        end_frame();
        tests_run++; if (ld !== 1'b1) begin tests_failed++; $display("FAIL midrst_next_ld got=%b exp=1", ld); end
        tests_run++; if (fields !== WORD_A) begin tests_failed++; $display("FAIL midrst_next_fields got=%h exp=%h", fields, WORD_A); end
    endtask

    task automatic test_back_to_back();
        send_bits(300'(WORD_B), W);
        @(negedge clk);
        cfg_en = 1'b0;
        cfg_i  = 1'b0;
        @(negedge clk);
        tests_run++; if (ld !== 1'b1) begin tests_failed++; $display("FAIL b2b_first_ld got=%b exp=1", ld); end
        tests_run++; if (fields !== WORD_B) begin tests_failed++; $display("FAIL b2b_first_fields got=%h exp=%h", fields, WORD_B); end
        tests_run++; if (c_ld !== 1'b1) begin tests_failed++; $display("FAIL b2b_chain_first_ld got=%b exp=1", c_ld); end
        // Next frame starts on the same cycle ld is high.
        cfg_en = 1'b1;
        cfg_i  = WORD_A[0];
        for (int i = 1; i < W; i++) begin
            @(negedge clk);
            cfg_i = WORD_A[i];
        end
        end_frame();
        tests_run++; if (ld !== 1'b1) begin tests_failed++; $display("FAIL b2b_second_ld got=%b exp=1", ld); end
        tests_run++; if (fields !== WORD_A) begin tests_failed++; $display("FAIL b2b_second_fields got=%h exp=%h", fields, WORD_A); end
        tests_run++; if (c_ld !== 1'b1) begin tests_failed++; $display("FAIL b2b_chain_ld got=%b exp=1", c_ld); end
        tests_run++; if (c_fields !== WORD_B) begin tests_failed++; $display("FAIL b2b_chain_fields got=%h exp=%h", c_fields, WORD_B); end
        tests_run++; if (c_cfg_err !== 1'b0) begin tests_failed++; $display("FAIL b2b_chain_err got=%b exp=0", c_cfg_err); end
        @(negedge clk);
        tests_run++; if (ld !== 1'b0) begin tests_failed++; $display("FAIL b2b_ld_pulse got=%b exp=0", ld); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
